aes_iterative_decrypt: RTL and testbench

Area-optimised AES-128 decryption core: one inverse round per clock over a single 128-bit state register, with round keys expanded on-chip and cached across blocks that share a key. It complements the unrolled, pipelined encoder datapath where area matters more than throughput (e.g. a bulk-encrypt pipeline with a low-rate decrypt return path). Blocks enter and leave through valid/ready handshakes.

---
 rtl/AESDefinitions.sv | 92 +++++++++
 rtl/InverseRoundComb.sv | 42 ++++
 rtl/aes_iterative_decrypt.sv | 138 +++++++++++++
 tb/tb_aes_iterative_decrypt.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/AESDefinitions.sv
`default_nettype none
// ----------------------------------------------------------------------------
// AESDefinitions : shared AES-128 types, Rcon, S-boxes, key-step   rev 1.0
// ----------------------------------------------------------------------------
package AESDefinitions;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  typedef logic [127:0] roundKey_t;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } core_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic roundKey_t key_step(input roundKey_t prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/InverseRoundComb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// InverseRoundComb : InvShiftRows/InvSubBytes/AddRoundKey[/InvMixColumns]  rev 1.0
// ----------------------------------------------------------------------------
module InverseRoundComb
  import AESDefinitions::*;
(
  input  state_t    state_in_i,
  input  roundKey_t round_key_i,
  input  logic      final_i,
  output state_t    state_out_o
);

  logic [7:0] ark_b [16];
  logic [7:0] mix_b [16];

  // Byte index is row + 4*column; row r rotates right by r on the inverse path.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = r + 4 * c;
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign ark_b[DST] = inv_sbox(state_in_i[127-8*SRC -: 8]) ^ round_key_i[127-8*DST -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_b[4*c];
    assign a1 = ark_b[4*c+1];
    assign a2 = ark_b[4*c+2];
    assign a3 = ark_b[4*c+3];

    assign mix_b[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mix_b[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mix_b[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mix_b[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  for (genvar b = 0; b < 16; b++) begin : g_out
    assign state_out_o[127-8*b -: 8] = final_i ? ark_b[b] : mix_b[b];
  end

endmodule
`default_nettype wire

// File: rtl/aes_iterative_decrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_iterative_decrypt : one-inverse-round-per-clock AES-128 decryptor  rev 1.0
// ----------------------------------------------------------------------------
module aes_iterative_decrypt
  import AESDefinitions::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  state_t in_data_i,
  input  key_t   in_key_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output state_t out_data_o,
  output logic   busy_o
);

  core_state_e state_q;
  state_t      data_q;
  roundKey_t   rk_q [NUM_ROUNDS+1];
  logic [3:0]  cnt_q;
  logic        cache_valid_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic        accept;
  logic        cache_hit;
  roundKey_t   rk_prev;
  roundKey_t   rk_cur;
  roundKey_t   rk_next_d;
  state_t      round_out;
  state_t      data_d;

  assign accept    = in_valid_i && (state_q == IDLE);
  // rk[0] always holds the key of the last accepted block, so it doubles as the cached key.
  assign cache_hit = KEY_CACHE && cache_valid_q && (in_key_i == rk_q[0]);

  always_comb begin
    rk_prev = rk_q[0];
    rk_cur  = rk_q[0];
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (cnt_q == 4'(i + 1)) rk_prev = rk_q[i];
      if (cnt_q == 4'(i))     rk_cur  = rk_q[i];
    end
  end

  assign rk_next_d = key_step(rk_prev, rcon(cnt_q));

  InverseRoundComb u_inv_round (
    .state_in_i  (data_q),
    .round_key_i (rk_cur),
    .final_i     (cnt_q == 4'd0),
    .state_out_o (round_out)
  );

  always_comb begin
    data_d = round_out;
    if (cnt_q == 4'(NUM_ROUNDS)) data_d = data_q ^ rk_cur;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      rk_q[0] <= in_key_i;
    end else if (state_q == KEYEXP) begin
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (cnt_q == 4'(i)) rk_q[i] <= rk_next_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      data_q        <= '0;
      cnt_q         <= 4'd0;
      cache_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q     <= in_data_i;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (cache_hit) begin
              state_q <= ROUND;
              cnt_q   <= 4'(NUM_ROUNDS);
            end else begin
              state_q       <= KEYEXP;
              cnt_q         <= 4'd1;
              cache_valid_q <= 1'b0;
            end
          end
        end
        KEYEXP: begin
          if (cnt_q == 4'(NUM_ROUNDS)) begin
            cache_valid_q <= KEY_CACHE;
            state_q       <= ROUND;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          data_q <= data_d;
          if (cnt_q == 4'd0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = data_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_iterative_decrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_iterative_decrypt : scoreboard bench, forward-AES reference    rev 1.0
// ----------------------------------------------------------------------------
module tb_aes_iterative_decrypt;

  localparam bit KC       = 1'b1;
  localparam int LAT_MISS = 22;
  localparam int LAT_HIT  = 12;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         fixed_ready = 1'b1;
  logic         rnd_ready = 1'b0;
  logic         rnd_bit = 1'b1;
  logic         out_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] out_data;

  assign out_ready = rnd_ready ? rnd_bit : fixed_ready;

  aes_iterative_decrypt #(.KEY_CACHE(KC)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_key_i    (in_key),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           due;
    int           busy_n;
  } exp_t;

  exp_t         sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         cache_v = 1'b0;
  logic [127:0] cache_k = '0;
  int           last_a = 0;
  logic [7:0]   sbox_t [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from its definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] c;
    logic [7:0] inv;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_t[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_exp(input logic [127:0] key, input logic [127:0] pt, input bit want);
    int   lat;
    exp_t e;
    lat     = (KC && cache_v && (key == cache_k)) ? LAT_HIT : LAT_MISS;
    cache_v = 1'b1;
    cache_k = key;
    last_a  = cyc;
    if (want) begin
      e.pt = pt; e.due = cyc + lat; e.busy_n = lat - 1;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt, input bit want);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    chk("accept_wait", 128'(in_ready), 128'(1));
    in_data  = ct;
    in_key   = key;
    in_valid = 1'b1;
    push_exp(key, pt, want);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !in_ready) && n < 400) begin @(negedge clk); n++; end
    chk("drain_pending", 128'(sb.size()), 128'(0));
  endtask

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom() & 1);
  end

  // Monitor: checks every DONE cycle against the head of the scoreboard.
  initial begin
    logic prev_valid;
    int   busy_cnt;
    prev_valid = 1'b0;
    busy_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        busy_cnt   = 0;
      end else begin
        if (busy) busy_cnt++;
        if (out_valid) begin
          chk("in_ready_in_done", 128'(in_ready), 128'(0));
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 128'(out_valid), 128'(0));
          end else begin
            if (!prev_valid) begin
              chk("latency_cycle", 128'(cyc), 128'(sb[0].due));
              chk("busy_cycles", 128'(busy_cnt), 128'(sb[0].busy_n));
              busy_cnt = 0;
            end
            chk("out_data", out_data, sb[0].pt);
            if (out_ready) void'(sb.pop_front());
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] p, k, k2, p2, kprev;
    int n;
    build_sbox();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_out_data", out_data, 128'(0));

    send(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_drain();

    send(B_CT, B_KEY, B_PT, 1'b1);
    wait_drain();
    send(B_CT, B_KEY, B_PT, 1'b1);
    wait_drain();

    send(C1_CT, C1_KEY, C1_PT, 1'b1);
    send(B_CT, B_KEY, B_PT, 1'b1);
    wait_drain();

    // Back-pressure with a second block parked on the input the whole time.
    p = rnd128(); k = rnd128();
    p2 = rnd128(); k2 = rnd128();
    @(posedge clk); #1 fixed_ready = 1'b0;
    send(encrypt(p, k), k, p, 1'b1);
    in_data = encrypt(p2, k2); in_key = k2; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid_seen", 128'(out_valid), 128'(1));
    repeat (50) begin @(posedge clk); #1; end
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_release", 128'(in_ready), 128'(1));
    chk("bp_out_valid_after_release", 128'(out_valid), 128'(0));
    push_exp(k2, p2, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();

    // Reset during ROUND aborts the block and invalidates the key cache.
    send(C1_CT, C1_KEY, C1_PT, 1'b0);
    while (cyc < last_a + 15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cache_v = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
    chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    send(C1_CT, C1_KEY, C1_PT, 1'b1);
    wait_drain();

    // in_valid pulses with junk while busy must not disturb the block.
    p = rnd128(); k = rnd128();
    send(encrypt(p, k), k, p, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'(i % 2);
      in_data  = rnd128();
      in_key   = rnd128();
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();

    // Random blocks, random key reuse, random consumer stalls.
    rnd_ready = 1'b1;
    kprev = rnd128();
    for (int i = 0; i < 12; i++) begin
      p = rnd128();
      k = ($urandom() % 2 == 0) ? kprev : rnd128();
      send(encrypt(p, k), k, p, 1'b1);
      kprev = k;
    end
    wait_drain();
    @(posedge clk); #1 rnd_ready = 1'b0;

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
